tl_mem: RTL and testbench

TL_MEM -- requirements
Module: tl_mem

---
 rtl/tl_mem_pkg.sv | 30 +++
 rtl/tl_mem.sv | 193 +++++++++++++++++++
 tb/tb_tl_mem.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_mem_pkg.sv
// Shared definitions for the TileLink-UL memory slave (tl_mem).
// Holds TileLink opcode constants, the default row count and the FSM state type.
package tl_mem_pkg;

    localparam logic [2:0] OP_PUT_FULL        = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] OP_GET             = 3'd4;
    localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

    localparam int DP_DEFAULT = 16384;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUT  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Number of 128-bit beats a request of 2^size bytes occupies
    function automatic logic [2:0] beatsForSize(input logic [7:0] size);
        if (size <= 8'd4) begin
            return 3'd1;
        end else if (size == 8'd5) begin
            return 3'd2;
        end else begin
            return 3'd4;
        end
    endfunction

endpackage

// File: rtl/tl_mem.sv
// TileLink-UL memory slave with a 128-bit wide inline RAM named "ram".
// Rows are selected by address[17:4] (upper bits alias), bursts wrap at DP.
// Optional feature macro: TL_MEM_OPCODE_CHECK_EN -- when defined, unsupported
// opcodes are answered with a denied AccessAck; otherwise with a plain AccessAck.
// The RAM is deliberately not reset so that hierarchical preloads survive reset.
module tl_mem
    import tl_mem_pkg::*;
#(
    parameter int DP = DP_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   tlslv_a_opcode,
    input  logic [2:0]   tlslv_a_param,
    input  logic [7:0]   tlslv_a_size,
    input  logic [2:0]   tlslv_a_source,
    input  logic [31:0]  tlslv_a_address,
    input  logic [15:0]  tlslv_a_mask,
    input  logic [127:0] tlslv_a_data,
    input  logic         tlslv_a_corrupt,
    input  logic         tlslv_a_valid,
    output logic         tlslv_a_ready,
    output logic [2:0]   tlslv_d_opcode,
    output logic [1:0]   tlslv_d_param,
    output logic [7:0]   tlslv_d_size,
    output logic [2:0]   tlslv_d_source,
    output logic [2:0]   tlslv_d_sink,
    output logic         tlslv_d_denied,
    output logic [127:0] tlslv_d_data,
    output logic         tlslv_d_corrupt,
    output logic         tlslv_d_valid,
    input  logic         tlslv_d_ready
);

    localparam int AW = (DP > 1) ? $clog2(DP) : 1;

`ifdef TL_MEM_OPCODE_CHECK_EN
    localparam logic OpcodeCheckEn = 1'b1;
`else
    localparam logic OpcodeCheckEn = 1'b0;
`endif

    logic [127:0] ram [DP];

    state_e         state_q, state_d;
    logic [2:0]     beat_q, total_q;
    logic [AW-1:0]  row_q;
    logic [2:0]     dOpcode_q;
    logic [7:0]     dSize_q;
    logic [2:0]     dSource_q;
    logic           dDenied_q;
    logic [127:0]   dData_q;

    logic           aFire, dFire, isGet, isPut, lastBeat, writeEn;
    logic [2:0]     reqBeats;
    logic [AW-1:0]  startRow, writeRow;
    logic           unusedBits;

    function automatic logic [AW-1:0] nextRow(input logic [AW-1:0] row);
        return (row == AW'(DP - 1)) ? '0 : row + AW'(1);
    endfunction

    assign isGet      = (tlslv_a_opcode == OP_GET);
    assign isPut      = (tlslv_a_opcode == OP_PUT_FULL) || (tlslv_a_opcode == OP_PUT_PARTIAL);
    assign reqBeats   = beatsForSize(tlslv_a_size);
    assign startRow   = AW'(32'(tlslv_a_address[17:4]) % DP);
    assign aFire      = tlslv_a_valid & tlslv_a_ready;
    assign dFire      = tlslv_d_valid & tlslv_d_ready;
    assign lastBeat   = (beat_q == total_q - 3'd1);
    assign writeEn    = aFire && (((state_q == IDLE) && isPut) || (state_q == PUT));
    assign writeRow   = (state_q == PUT) ? row_q : startRow;
    assign unusedBits = ^{tlslv_a_param, tlslv_a_corrupt, tlslv_a_address[31:18], tlslv_a_address[3:0]};

    assign tlslv_a_ready   = (state_q != RESP);
    assign tlslv_d_valid   = (state_q == RESP);
    assign tlslv_d_opcode  = dOpcode_q;
    assign tlslv_d_param   = 2'b00;
    assign tlslv_d_size    = dSize_q;
    assign tlslv_d_source  = dSource_q;
    assign tlslv_d_sink    = 3'b000;
    assign tlslv_d_denied  = dDenied_q;
    assign tlslv_d_data    = dData_q;
    assign tlslv_d_corrupt = 1'b0;

    // Next-state logic: multi-beat Puts collect in PUT, everything else answers from RESP
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (aFire) begin
                    state_d = (isPut && (reqBeats != 3'd1)) ? PUT : RESP;
                end
            end
            PUT: begin
                if (aFire && lastBeat) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (dFire && lastBeat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any burst in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Beat counters, burst row pointer and the registered D-channel response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q    <= '0;
            total_q   <= '0;
            row_q     <= '0;
            dOpcode_q <= '0;
            dSize_q   <= '0;
            dSource_q <= '0;
            dDenied_q <= 1'b0;
            dData_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (aFire) begin
                        dSize_q   <= tlslv_a_size;
                        dSource_q <= tlslv_a_source;
                        dDenied_q <= 1'b0;
                        dOpcode_q <= OP_ACCESS_ACK;
                        dData_q   <= '0;
                        beat_q    <= '0;
                        total_q   <= 3'd1;
                        row_q     <= startRow;
                        if (isGet) begin
                            total_q   <= reqBeats;
                            dOpcode_q <= OP_ACCESS_ACK_DATA;
                            dData_q   <= ram[startRow];
                        end else if (isPut) begin
                            if (reqBeats != 3'd1) begin
                                total_q <= reqBeats;
                                beat_q  <= 3'd1;
                                row_q   <= nextRow(startRow);
                            end
                        end else begin
                            dDenied_q <= OpcodeCheckEn;
                        end
                    end
                end
                PUT: begin
                    if (aFire) begin
                        if (lastBeat) begin
                            beat_q  <= '0;
                            total_q <= 3'd1;
                        end else begin
                            beat_q <= beat_q + 3'd1;
                            row_q  <= nextRow(row_q);
                        end
                    end
                end
                RESP: begin
                    if (dFire) begin
                        if (lastBeat) begin
                            beat_q <= '0;
                        end else begin
                            beat_q  <= beat_q + 3'd1;
                            row_q   <= nextRow(row_q);
                            dData_q <= ram[nextRow(row_q)];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte-masked write port; no reset so preloaded and written rows persist
    always_ff @(posedge clk) begin
        if (writeEn) begin
            for (int b = 0; b < 16; b++) begin
                if (tlslv_a_mask[b]) begin
                    ram[writeRow][8*b +: 8] <= tlslv_a_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_tl_mem.sv
// Self-checking bench for tl_mem: directed scenarios plus randomized traffic
// against a byte-level reference memory kept in the bench.
module tb_tl_mem;
    import tl_mem_pkg::*;

    localparam int DP = 16384;

`ifdef TL_MEM_OPCODE_CHECK_EN
    localparam logic ExpDenied = 1'b1;
`else
    localparam logic ExpDenied = 1'b0;
`endif

    typedef struct packed {
        logic         valid;
        logic [2:0]   opcode;
        logic [1:0]   param;
        logic [7:0]   size;
        logic [2:0]   source;
        logic [2:0]   sink;
        logic         denied;
        logic         corrupt;
        logic [127:0] data;
    } dBeat_t;

    logic         clk;
    logic         rst_n;
    logic [2:0]   a_opcode, a_param, a_source;
    logic [7:0]   a_size;
    logic [31:0]  a_address;
    logic [15:0]  a_mask;
    logic [127:0] a_data;
    logic         a_corrupt, a_valid, a_ready;
    logic [2:0]   d_opcode, d_source, d_sink;
    logic [1:0]   d_param;
    logic [7:0]   d_size;
    logic         d_denied, d_corrupt, d_valid, d_ready;
    logic [127:0] d_data;

    int errors = 0;
    int checks = 0;
    logic [127:0] model [DP];

    tl_mem #(.DP(DP)) dut (
        .clk(clk), .rst_n(rst_n),
        .tlslv_a_opcode(a_opcode), .tlslv_a_param(a_param), .tlslv_a_size(a_size),
        .tlslv_a_source(a_source), .tlslv_a_address(a_address), .tlslv_a_mask(a_mask),
        .tlslv_a_data(a_data), .tlslv_a_corrupt(a_corrupt), .tlslv_a_valid(a_valid),
        .tlslv_a_ready(a_ready),
        .tlslv_d_opcode(d_opcode), .tlslv_d_param(d_param), .tlslv_d_size(d_size),
        .tlslv_d_source(d_source), .tlslv_d_sink(d_sink), .tlslv_d_denied(d_denied),
        .tlslv_d_data(d_data), .tlslv_d_corrupt(d_corrupt), .tlslv_d_valid(d_valid),
        .tlslv_d_ready(d_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int rowOf(input logic [31:0] addr);
        return int'((addr >> 4) % DP);
    endfunction

    function automatic int beatsOf(input logic [7:0] size);
        if (size <= 8'd4) return 1;
        if (size == 8'd5) return 2;
        return 4;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic modelWrite(input int row, input logic [15:0] mask, input logic [127:0] data);
        for (int b = 0; b < 16; b++) begin
            if (mask[b]) model[row][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    // Presents one A beat and waits (bounded) for it to be accepted; returns just after a negedge
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] size, input logic [2:0] src,
                                 input logic [31:0] addr, input logic [15:0] mask,
                                 input logic [127:0] data, output bit accepted);
        accepted  = 1'b0;
        a_opcode  = op;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_param   = 3'($urandom);
        a_corrupt = 1'b0;
        a_valid   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (a_ready === 1'b1) begin
                @(posedge clk);
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    // Waits (bounded) for a D beat, optionally stalls, captures it and handshakes it
    task automatic recvBeat(input int stall, output bit got, output dBeat_t b);
        got = 1'b0;
        b   = '0;
        for (int i = 0; i < 20; i++) begin
            if (d_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (got) begin
            repeat (stall) @(negedge clk);
            b.valid = d_valid;  b.opcode = d_opcode;  b.param = d_param;
            b.size = d_size;    b.source = d_source;  b.sink = d_sink;
            b.denied = d_denied; b.corrupt = d_corrupt; b.data = d_data;
            d_ready = 1'b1;
            @(negedge clk);
            d_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0; d_ready = 1'b0;
        for (int i = 0; i < DP; i++) begin
            model[i] = rnd128();
            dut.ram[i] = model[i];
        end
        repeat (2) @(negedge clk);
        checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dvalid: got %b expected 0", d_valid); end
        checks++; if ({d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data} !== '0) begin
            errors++; $display("[TB] FAIL reset_dfields: got op=%h sz=%h src=%h data=%h expected all 0", d_opcode, d_size, d_source, d_data); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (a_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_aready: got %b expected 1", a_ready); end
    endtask

    task automatic test_get_preload();
        bit acc, got;
        dBeat_t b;
        logic [127:0] exp;
        exp = 128'h0123456789ABCDEF0123456789ABCDEF;
        dut.ram[0] = exp;
        model[0] = exp;
        applyStimulus(OP_GET, 8'd4, 3'd2, 32'h8000_0000, 16'hFFFF, '0, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL get0_accept: got %b expected 1", acc); end
        checks++; if (d_valid !== 1'b1) begin errors++; $display("[TB] FAIL get0_latency: got d_valid=%b expected 1", d_valid); end
        recvBeat(0, got, b);
        checks++; if (got !== 1'b1 || b.opcode !== OP_ACCESS_ACK_DATA) begin
            errors++; $display("[TB] FAIL get0_opcode: got %h expected %h", b.opcode, OP_ACCESS_ACK_DATA); end
        checks++; if (b.data !== exp) begin errors++; $display("[TB] FAIL get0_data: got %h expected %h", b.data, exp); end
        checks++; if ({d_valid, a_ready} !== 2'b01) begin
            errors++; $display("[TB] FAIL get0_done: got valid/ready=%b expected 01", {d_valid, a_ready}); end
    endtask

    task automatic test_put_partial();
        bit acc, got;
        dBeat_t b;
        logic [127:0] orig;
        orig = model[1];
        applyStimulus(OP_PUT_PARTIAL, 8'd4, 3'd1, 32'h0000_0010, 16'h000F, {128{1'b1}}, acc);
        modelWrite(1, 16'h000F, {128{1'b1}});
        recvBeat(0, got, b);
        checks++; if (got !== 1'b1 || b.opcode !== OP_ACCESS_ACK || b.denied !== 1'b0) begin
            errors++; $display("[TB] FAIL putp_ack: got op=%h denied=%b expected op=0 denied=0", b.opcode, b.denied); end
        applyStimulus(OP_GET, 8'd4, 3'd1, 32'h0000_0010, 16'hFFFF, '0, acc);
        recvBeat(0, got, b);
        checks++; if (b.opcode !== OP_ACCESS_ACK_DATA) begin
            errors++; $display("[TB] FAIL putp_get_opcode: got %h expected 1", b.opcode); end
        checks++; if (b.data[31:0] !== 32'hFFFF_FFFF) begin
            errors++; $display("[TB] FAIL putp_low: got %h expected ffffffff", b.data[31:0]); end
        checks++; if (b.data[127:32] !== orig[127:32]) begin
            errors++; $display("[TB] FAIL putp_high: got %h expected %h", b.data[127:32], orig[127:32]); end
    endtask

    task automatic test_wrap_stall();
        bit acc, got;
        int row;
        applyStimulus(OP_GET, 8'd6, 3'd3, 32'h0003_FFE0, 16'hFFFF, '0, acc);
        for (int k = 0; k < 4; k++) begin
            row = (16382 + k) % DP;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (d_valid === 1'b1) begin got = 1'b1; break; end
                @(negedge clk);
            end
            checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL wrap_valid: beat %0d got no d_valid expected 1", k); end
            for (int s = 0; s < 2; s++) begin
                checks++; if (d_valid !== 1'b1 || d_data !== model[row]) begin
                    errors++; $display("[TB] FAIL wrap_stall: beat %0d got %h expected %h", k, d_data, model[row]); end
                @(negedge clk);
            end
            checks++; if (d_opcode !== OP_ACCESS_ACK_DATA || d_data !== model[row]) begin
                errors++; $display("[TB] FAIL wrap_data: beat %0d row %0d got %h expected %h", k, row, d_data, model[row]); end
            d_ready = 1'b1;
            @(negedge clk);
            d_ready = 1'b0;
        end
        checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_end: got d_valid=%b expected 0", d_valid); end
    endtask

    task automatic test_put_multi();
        bit acc, got;
        dBeat_t b;
        int row;
        logic [127:0] d0, d1;
        row = int'($urandom_range(16, 1000));
        d0 = rnd128();
        d1 = rnd128();
        applyStimulus(OP_PUT_FULL, 8'd5, 3'd5, 32'(row) << 4, 16'hFFFF, d0, acc);
        modelWrite(row, 16'hFFFF, d0);
        checks++; if ({a_ready, d_valid} !== 2'b10) begin
            errors++; $display("[TB] FAIL putm_mid: got ready/valid=%b expected 10", {a_ready, d_valid}); end
        applyStimulus(OP_PUT_FULL, 8'd5, 3'd5, 32'(row) << 4, 16'hFFFF, d1, acc);
        modelWrite((row + 1) % DP, 16'hFFFF, d1);
        for (int s = 0; s < 3; s++) begin
            checks++; if ({a_ready, d_valid} !== 2'b01) begin
                errors++; $display("[TB] FAIL putm_hold: got ready/valid=%b expected 01", {a_ready, d_valid}); end
            @(negedge clk);
        end
        recvBeat(0, got, b);
        checks++; if ({b.opcode, b.source, b.size} !== {OP_ACCESS_ACK, 3'd5, 8'd5}) begin
            errors++; $display("[TB] FAIL putm_ack: got op=%h src=%h size=%h expected 0/5/5", b.opcode, b.source, b.size); end
        checks++; if ({d_valid, a_ready} !== 2'b01) begin
            errors++; $display("[TB] FAIL putm_single: got valid/ready=%b expected 01", {d_valid, a_ready}); end
        applyStimulus(OP_GET, 8'd5, 3'd0, 32'(row) << 4, 16'hFFFF, '0, acc);
        for (int k = 0; k < 2; k++) begin
            recvBeat(1, got, b);
            checks++; if (b.data !== model[(row + k) % DP]) begin
                errors++; $display("[TB] FAIL putm_readback: beat %0d got %h expected %h", k, b.data, model[(row + k) % DP]); end
        end
    endtask

    task automatic test_bad_opcode();
        bit acc, got;
        dBeat_t b;
        int row;
        row = 2000;
        applyStimulus(3'd6, 8'd4, 3'd4, 32'(row) << 4, 16'hFFFF, rnd128(), acc);
        recvBeat(0, got, b);
        checks++; if (got !== 1'b1 || b.opcode !== OP_ACCESS_ACK || b.denied !== ExpDenied) begin
            errors++; $display("[TB] FAIL badop_ack: got op=%h denied=%b expected op=0 denied=%b", b.opcode, b.denied, ExpDenied); end
        checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL badop_single: got d_valid=%b expected 0", d_valid); end
        applyStimulus(OP_GET, 8'd4, 3'd4, 32'(row) << 4, 16'hFFFF, '0, acc);
        recvBeat(0, got, b);
        checks++; if (b.data !== model[row] || b.denied !== 1'b0) begin
            errors++; $display("[TB] FAIL badop_nowrite: got %h denied=%b expected %h denied=0", b.data, b.denied, model[row]); end
    endtask

    task automatic test_random();
        bit acc, got;
        dBeat_t b;
        int kind, row, nb;
        logic [7:0] size;
        logic [2:0] src, op;
        logic [31:0] addr;
        logic [15:0] mask;
        logic [127:0] data;
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 2));
            size = 8'($urandom_range(0, 7));
            src  = 3'($urandom);
            row  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(16380, 16383));
            addr = ($urandom & 32'hFFFC_0000) | (32'(row) << 4) | ($urandom & 32'h0000_000F);
            nb   = beatsOf(size);
            if (kind == 0) begin
                applyStimulus(OP_GET, size, src, addr, 16'hFFFF, '0, acc);
                for (int k = 0; k < nb; k++) begin
                    recvBeat(int'($urandom_range(0, 2)), got, b);
                    checks++; if ({got, b.opcode, b.param, b.size, b.source, b.sink, b.denied, b.corrupt} !==
                                  {1'b1, OP_ACCESS_ACK_DATA, 2'b0, size, src, 3'b0, 1'b0, 1'b0}) begin
                        errors++; $display("[TB] FAIL rnd_get_hdr: t=%0d beat %0d got op=%h size=%h src=%h expected 1/%h/%h",
                                           t, k, b.opcode, b.size, b.source, size, src); end
                    checks++; if (b.data !== model[(row + k) % DP]) begin
                        errors++; $display("[TB] FAIL rnd_get_data: t=%0d beat %0d got %h expected %h",
                                           t, k, b.data, model[(row + k) % DP]); end
                end
            end else begin
                op = (kind == 1) ? OP_PUT_FULL : OP_PUT_PARTIAL;
                for (int k = 0; k < nb; k++) begin
                    mask = (kind == 1) ? 16'hFFFF : 16'($urandom);
                    data = rnd128();
                    applyStimulus(op, size, src, addr, mask, data, acc);
                    modelWrite((row + k) % DP, mask, data);
                    checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL rnd_put_accept: t=%0d beat %0d got 0 expected 1", t, k); end
                end
                recvBeat(int'($urandom_range(0, 2)), got, b);
                checks++; if ({got, b.opcode, b.param, b.size, b.source, b.sink, b.denied, b.corrupt} !==
                              {1'b1, OP_ACCESS_ACK, 2'b0, size, src, 3'b0, 1'b0, 1'b0}) begin
                    errors++; $display("[TB] FAIL rnd_put_ack: t=%0d got op=%h size=%h src=%h expected 0/%h/%h",
                                       t, b.opcode, b.size, b.source, size, src); end
            end
            checks++; if ({d_valid, a_ready} !== 2'b01) begin
                errors++; $display("[TB] FAIL rnd_idle: t=%0d got valid/ready=%b expected 01", t, {d_valid, a_ready}); end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit acc, got;
        dBeat_t b;
        logic [127:0] d0, d1;
        d0 = rnd128();
        d1 = rnd128();
        applyStimulus(OP_PUT_FULL, 8'd5, 3'd1, 32'(100) << 4, 16'hFFFF, d0, acc);
        applyStimulus(OP_PUT_FULL, 8'd5, 3'd1, 32'(100) << 4, 16'hFFFF, d1, acc);
        modelWrite(100, 16'hFFFF, d0);
        modelWrite(101, 16'hFFFF, d1);
        recvBeat(0, got, b);
        applyStimulus(OP_GET, 8'd6, 3'd2, 32'(200) << 4, 16'hFFFF, '0, acc);
        recvBeat(0, got, b);
        checks++; if (d_valid !== 1'b1 || d_data !== model[201]) begin
            errors++; $display("[TB] FAIL rst_beat2: got valid=%b data=%h expected 1 %h", d_valid, d_data, model[201]); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_async: got d_valid=%b expected 0", d_valid); end
        for (int r = 100; r < 102; r++) begin
            checks++; if (dut.ram[r] !== model[r]) begin
                errors++; $display("[TB] FAIL rst_retain: row %0d got %h expected %h", r, dut.ram[r], model[r]); end
        end
        d_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        d_ready = 1'b0;
        checks++; if ({d_valid, a_ready} !== 2'b01) begin
            errors++; $display("[TB] FAIL rst_after: got valid/ready=%b expected 01", {d_valid, a_ready}); end
        applyStimulus(OP_GET, 8'd4, 3'd0, 32'(101) << 4, 16'hFFFF, '0, acc);
        recvBeat(0, got, b);
        checks++; if (b.data !== model[101]) begin
            errors++; $display("[TB] FAIL rst_readback: got %h expected %h", b.data, model[101]); end
    endtask

    initial begin
        test_reset();
        test_get_preload();
        test_put_partial();
        test_wrap_stall();
        test_put_multi();
        test_bad_opcode();
        test_random();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
